// File: rtl/ulpb_ctrl_pkg.sv
// ulpb_ctrl_pkg: shared types and constants for the ULPB ring-head bus
// controller.
//   ctrl_state_e   : controller FSM states (IDLE, START, RUN, POST, PARK)
//   phase_e        : mirror of the node phase sequence seen on BUS_CLK rises
//   ULPB_RESET_CNT : default bus-reset posedge count, shared with ulpb_node32
//   next_phase()   : phase advance on one BUS_CLK rising edge
package ulpb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_POST  = 3'd3,
    ST_PARK  = 3'd4
  } ctrl_state_e;

  typedef enum logic [2:0] {
    PH_ARBI   = 3'd0,
    PH_DRIVE1 = 3'd1,
    PH_LATCH1 = 3'd2,
    PH_DRIVE2 = 3'd3,
    PH_LATCH2 = 3'd4
  } phase_e;

  localparam int unsigned ULPB_RESET_CNT = 4;

  // ARBI is only visited once per transaction; afterwards the four data
  // phases repeat.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_ARBI:   next_phase = PH_DRIVE1;
      PH_DRIVE1: next_phase = PH_LATCH1;
      PH_LATCH1: next_phase = PH_DRIVE2;
      PH_DRIVE2: next_phase = PH_LATCH2;
      PH_LATCH2: next_phase = PH_DRIVE1;
      default:   next_phase = PH_ARBI;
    endcase
  endfunction

endpackage

// File: rtl/ulpb_bus_ctrl_clk_gen.sv
// ulpb_clk_gen: bus-clock half-period divider.
//   CLK, RESET : system clock, asynchronous active-low reset
//   en         : run the divider; when low BUS_CLK parks high and the
//                counter restarts, so the first edge after enabling is a
//                fall CLK_DIV cycles later
//   bus_clk    : registered bus clock (idle high)
//   rise_pre   : high in the system cycle just before bus_clk rises
//   fall_pre   : high in the system cycle just before bus_clk falls
//   rise       : high in the first system cycle after bus_clk rose
module ulpb_clk_gen
  import ulpb_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic bus_clk,
  output logic rise_pre,
  output logic fall_pre,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_clk_q, bus_clk_d;
  logic             rise_q, rise_d;
  logic             at_end_s;

  // Half-period counter and toggle decision
  always_comb begin
    at_end_s  = (cnt_q == CNT_LAST);
    rise_pre  = en && at_end_s && !bus_clk_q;
    fall_pre  = en && at_end_s && bus_clk_q;
    rise_d    = rise_pre;
    cnt_d     = cnt_q;
    bus_clk_d = bus_clk_q;
    if (!en) begin
      cnt_d     = {CNT_W{1'b0}};
      bus_clk_d = 1'b1;
    end else if (at_end_s) begin
      cnt_d     = {CNT_W{1'b0}};
      bus_clk_d = ~bus_clk_q;
    end else begin
      cnt_d     = cnt_q + CNT_W'(1);
      bus_clk_d = bus_clk_q;
    end
  end

  // Divider registers; reset parks the bus clock high immediately
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q     <= {CNT_W{1'b0}};
      bus_clk_q <= 1'b1;
      rise_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_clk_q <= bus_clk_d;
      rise_q    <= rise_d;
    end
  end

  assign bus_clk = bus_clk_q;
  assign rise    = rise_q;

endmodule

// File: rtl/ulpb_bus_ctrl.sv
// ulpb_bus_ctrl: ring-head controller that generates BUS_CLK for the ULPB
// ring, from request detection through arbitration, data, interjection,
// acknowledge and bus-reset phases, then parks the clock high.
//   CLK, RESET  : system clock, asynchronous active-low reset
//   DIN         : ring return from the last node (asynchronous)
//   DOUT        : ring out to the first node (1 until the first rise,
//                 then DIN passed straight through)
//   BUS_CLK     : ring clock, idle high
//   BUSY        : request detected until the clock is parked
//   TRANS_DONE  : one-cycle pulse as the controller returns to IDLE
//   TIMEOUT     : sticky watchdog flag, cleared by TIMEOUT_ACK
// Optional feature: define ULPB_CTRL_WATCHDOG_EN to enable the MAX_BITS
// bit-count watchdog; otherwise TIMEOUT is 0 and TIMEOUT_ACK is ignored.
module ulpb_bus_ctrl
  import ulpb_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned RESET_CNT = ULPB_RESET_CNT,
  parameter int unsigned MAX_BITS  = 1024
) (
  input  logic CLK,
  input  logic RESET,
  input  logic DIN,
  output logic DOUT,
  output logic BUS_CLK,
  output logic BUSY,
  output logic TRANS_DONE,
  output logic TIMEOUT,
  input  logic TIMEOUT_ACK
);

  localparam int unsigned POST_LOAD = 4 + RESET_CNT;
  localparam int unsigned POST_W    = $clog2(POST_LOAD + 1);
  localparam int unsigned DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic              din_meta_q, din_s_q;
  ctrl_state_e       state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [1:0]        samp_q, samp_d;
  logic [POST_W-1:0] post_cnt_q, post_cnt_d;
  logic [DIV_W-1:0]  park_cnt_q, park_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fwd_q, fwd_d;
  logic              force_q, force_d;
  logic              timeout_q, timeout_d;
  logic              clk_en_s, rise_pre_s, fall_pre_s, bus_clk_s;
  logic              interj_s, invert_s;
  logic              unused_rise_s;

`ifdef ULPB_CTRL_WATCHDOG_EN
  localparam int unsigned BIT_W = $clog2(MAX_BITS) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MAX_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_SAT  = {BIT_W{1'b1}};
  logic [BIT_W-1:0] bits_q, bits_d;
  logic             wd_fire_s;
`else
  localparam int unsigned unused_max_bits = MAX_BITS;
  logic unused_ack_s;
  assign unused_ack_s = TIMEOUT_ACK;
`endif

  assign clk_en_s = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_POST);

  ulpb_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (clk_en_s),
    .bus_clk  (bus_clk_s),
    .rise_pre (rise_pre_s),
    .fall_pre (fall_pre_s),
    .rise     (unused_rise_s)
  );

  // Next-state logic; phase, sampling and edge counts all advance on the
  // cycle before a BUS_CLK rise so they change together with the rise.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    samp_d     = samp_q;
    post_cnt_d = post_cnt_q;
    park_cnt_d = park_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fwd_d      = fwd_q;
    force_d    = force_q;
`ifdef ULPB_CTRL_WATCHDOG_EN
    bits_d     = bits_q;
    wd_fire_s  = 1'b0;
`endif
    // A forced bit counts as an interjection even if the ring is not looped.
    interj_s   = (samp_q[1] ^ samp_q[0]) | force_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = PH_ARBI;
        fwd_d   = 1'b0;
        force_d = 1'b0;
        samp_d  = 2'b00;
`ifdef ULPB_CTRL_WATCHDOG_EN
        bits_d  = {BIT_W{1'b0}};
`endif
        if (!din_s_q) begin
          state_d = ST_START;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_START: begin
        if (fall_pre_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_START;
        end
      end
      ST_RUN, ST_POST: begin
        if (rise_pre_s) begin
          phase_d = next_phase(phase_q);
          case (phase_q)
            PH_ARBI:   fwd_d  = 1'b1;
            PH_DRIVE1: samp_d = {samp_q[0], din_s_q};
            PH_DRIVE2: samp_d = {samp_q[0], din_s_q};
            PH_LATCH2: begin
`ifdef ULPB_CTRL_WATCHDOG_EN
              if (bits_q != BIT_SAT) begin
                bits_d = bits_q + BIT_W'(1);
              end else begin
                bits_d = bits_q;
              end
`endif
              if ((state_q == ST_RUN) && interj_s) begin
                state_d    = ST_POST;
                post_cnt_d = POST_W'(POST_LOAD);
                force_d    = 1'b0;
              end else begin
`ifdef ULPB_CTRL_WATCHDOG_EN
                if ((state_q == ST_RUN) && (bits_q == BIT_LAST)) begin
                  wd_fire_s = 1'b1;
                  force_d   = 1'b1;
                end else begin
                  wd_fire_s = 1'b0;
                end
`endif
              end
            end
            default: begin
            end
          endcase
          if (state_q == ST_POST) begin
            if (post_cnt_q == POST_W'(1)) begin
              state_d    = ST_PARK;
              post_cnt_d = {POST_W{1'b0}};
              park_cnt_d = {DIV_W{1'b0}};
            end else begin
              post_cnt_d = post_cnt_q - POST_W'(1);
            end
          end else begin
            post_cnt_d = post_cnt_d;
          end
        end else begin
          phase_d = phase_q;
        end
      end
      ST_PARK: begin
        // Hold off the done pulse until the point the next fall would have been.
        if (park_cnt_q == DIV_LAST) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          fwd_d      = 1'b0;
          phase_d    = PH_ARBI;
          park_cnt_d = {DIV_W{1'b0}};
        end else begin
          park_cnt_d = park_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        fwd_d   = 1'b0;
        phase_d = PH_ARBI;
      end
    endcase
  end

  // Sticky timeout: a coincident set takes priority over the acknowledge
  always_comb begin
`ifdef ULPB_CTRL_WATCHDOG_EN
    if (wd_fire_s) begin
      timeout_d = 1'b1;
    end else if (TIMEOUT_ACK) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
`else
    timeout_d = 1'b0;
`endif
  end

  // DIN synchronizer; resets to the idle (released) level
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      din_meta_q <= 1'b1;
      din_s_q    <= 1'b1;
    end else begin
      din_meta_q <= DIN;
      din_s_q    <= din_meta_q;
    end
  end

  // Controller FSM, phase mirror and registered status outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_ARBI;
      samp_q     <= 2'b00;
      post_cnt_q <= {POST_W{1'b0}};
      park_cnt_q <= {DIV_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fwd_q      <= 1'b0;
      force_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      samp_q     <= samp_d;
      post_cnt_q <= post_cnt_d;
      park_cnt_q <= park_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fwd_q      <= fwd_d;
      force_q    <= force_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef ULPB_CTRL_WATCHDOG_EN
  // Completed-bit counter for the watchdog
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bits_q <= {BIT_W{1'b0}};
    end else begin
      bits_q <= bits_d;
    end
  end
`endif

  // DIN passes through combinationally so the ring has no extra latency.
  assign invert_s   = force_q && (phase_q == PH_DRIVE2);
  assign DOUT       = fwd_q ? (DIN ^ invert_s) : 1'b1;
  assign BUS_CLK    = bus_clk_s;
  assign BUSY       = busy_q;
  assign TRANS_DONE = done_q;
  assign TIMEOUT    = timeout_q;

endmodule
